// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid stage: state encoding and handshake helpers.
package pipe_pkg;

  // Encoding is {skid_valid, out_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } pipe_state_t;

  localparam logic HS_IDLE = 1'b0;
  localparam logic HS_XFER = 1'b1;

  function automatic logic pipe_xfer(input logic valid, input logic ready);
    return (valid & ready) ? HS_XFER : HS_IDLE;
  endfunction

endpackage

// File: rtl/pipe_data_hold.sv
// N-bit data holding register: async active-low reset, synchronous clear, load enable.
module pipe_data_hold #(
  parameter int unsigned     N         = 32,
  parameter logic [N-1:0]    RST_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     q <= RST_VALUE;
    else if (clear) q <= RST_VALUE;
    else if (load)  q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Backpressure-aware pipeline stage with one skid word; in_ready is a pure flop output.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned  N         = 32,
  parameter logic [N-1:0] RST_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  pipe_state_t state, state_n;
  logic        in_ready_q;
  logic        in_xfer, out_xfer;
  logic        out_load, skid_load;
  logic [N-1:0] out_d, skid_q;

  assign in_ready  = in_ready_q;
  assign out_valid = state[0];
  assign in_xfer   = pipe_xfer(in_valid, in_ready_q);
  assign out_xfer  = pipe_xfer(state[0], out_ready);
  // In TWO the only legal load of out_data is the skid word.
  assign out_d     = (state == ST_TWO) ? skid_q : in_data;

  always_comb begin
    state_n   = state;
    out_load  = 1'b0;
    skid_load = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_xfer) begin
          out_load = 1'b1;
          state_n  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          out_load = 1'b1;
        end else if (in_xfer) begin
          skid_load = 1'b1;
          state_n   = ST_TWO;
        end else if (out_xfer) begin
          state_n = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          out_load = 1'b1;
          state_n  = ST_ONE;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
    if (flush) state_n = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_n;
      in_ready_q <= ~state_n[1];
    end
  end

  pipe_data_hold #(.N(N), .RST_VALUE(RST_VALUE)) u_out_hold (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load  (out_load),
    .d     (out_d),
    .q     (out_data)
  );

  pipe_data_hold #(.N(N), .RST_VALUE(RST_VALUE)) u_skid_hold (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg.
module tb_pipe_skid_reg;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  int unsigned passed = 0;
  int unsigned total  = 0;

  pipe_skid_reg #(.N(N), .RST_VALUE('0)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0)
      $display("FAIL reset_held: out_valid=%b in_ready=%b out_data=%h want 0 1 00000000",
               out_valid, in_ready, out_data);
    else passed++;
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0)
        $display("FAIL reset_idle[%0d]: out_valid=%b in_ready=%b out_data=%h want 0 1 00000000",
                 i, out_valid, in_ready, out_data);
      else passed++;
    end
  endtask

  task automatic test_streaming();
    logic [N-1:0] vals [4];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = vals[i];
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== vals[i] || in_ready !== 1'b1)
        $display("FAIL stream[%0d]: out_valid=%b out_data=%h in_ready=%b want 1 %h 1",
                 i, out_valid, out_data, in_ready, vals[i]);
      else passed++;
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stream_drain: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_stall_skid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA1;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hA1 || in_ready !== 1'b1)
      $display("FAIL stall_first: out_valid=%b out_data=%h in_ready=%b want 1 000000a1 1",
               out_valid, out_data, in_ready);
    else passed++;
    in_data = 32'hA2;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hA1 || in_ready !== 1'b0)
      $display("FAIL stall_skid: out_valid=%b out_data=%h in_ready=%b want 1 000000a1 0",
               out_valid, out_data, in_ready);
    else passed++;
  endtask

  task automatic test_ignored_while_full();
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'hA1 || in_ready !== 1'b0)
        $display("FAIL full_hold[%0d]: out_valid=%b out_data=%h in_ready=%b want 1 000000a1 0",
                 i, out_valid, out_data, in_ready);
      else passed++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hA2 || in_ready !== 1'b1)
      $display("FAIL drain_skid: out_valid=%b out_data=%h in_ready=%b want 1 000000a2 1",
               out_valid, out_data, in_ready);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL drain_empty: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hB1;
    tick();
    in_data   = 32'hB2;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hB1 || in_ready !== 1'b0)
      $display("FAIL flush_setup: out_valid=%b out_data=%h in_ready=%b want 1 000000b1 0",
               out_valid, out_data, in_ready);
    else passed++;
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'h77;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0)
      $display("FAIL flush_state: out_valid=%b in_ready=%b out_data=%h want 0 1 00000000",
               out_valid, in_ready, out_data);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || out_data !== 32'h0)
        $display("FAIL flush_quiet[%0d]: out_valid=%b out_data=%h want 0 00000000",
                 i, out_valid, out_data);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h55)
      $display("FAIL areset_setup: out_valid=%b out_data=%h want 1 00000055", out_valid, out_data);
    else passed++;
    #2 reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1)
      $display("FAIL areset_async: out_valid=%b out_data=%h in_ready=%b want 0 00000000 1",
               out_valid, out_data, in_ready);
    else passed++;
    @(negedge clk) reset = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h66;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h66)
      $display("FAIL areset_next: out_valid=%b out_data=%h want 1 00000066", out_valid, out_data);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL areset_alone: out_valid=%b want 0", out_valid);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_skid();
    test_ignored_while_full();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Backpressure-aware pipeline stage register for the datapath; the consuming counterpart of the plain enable-controlled storage register.
- Accepts words from an upstream producer with a valid/ready handshake and presents them downstream with the same handshake.
- Holds one overflow ("skid") word, so upstream in_ready is a pure register output and does not combinationally depend on out_ready.
- Sits between pipeline stages (e.g. IF/ID, ID/EX) wherever a stage can stall.

Parameters:
- N, 32, data width in bits.
- RST_VALUE, 0, value loaded into out_data and the skid word on reset and on flush.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline flush; discards all held words.
- in_valid  input  1  upstream word present on in_data.
- in_ready  output  1  stage can accept a word this cycle (registered).
- in_data  input  N  upstream data.
- out_valid  output  1  out_data holds a valid word (registered).
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  N  downstream data (registered).

Behaviour:
- Handshake rules:
  - Transfer occurs on a rising clk edge when valid and ready are both 1 on that side.
  - Once out_valid=1, out_data must not change until out_ready=1 or flush.
- Reset: reset=0 forces the following immediately, regardless of clk:
  - out_valid=0, out_data=RST_VALUE
  - in_ready=1, skid word=RST_VALUE, state=EMPTY
- States (skid_valid, out_valid):
  - EMPTY (0,0)
  - ONE (0,1)
  - TWO (1,1)
  - (1,0) is illegal; it must be unreachable.
- in_ready = NOT skid_valid, held as a flop updated with the state.
- Transitions (in_xfer = in_valid&in_ready, out_xfer = out_valid&out_ready):
  - EMPTY, in_xfer: out_data<=in_data, go ONE. No in_xfer: stay.
  - ONE, in_xfer & out_xfer: out_data<=in_data, stay ONE (full throughput).
  - ONE, in_xfer & !out_xfer: skid<=in_data, go TWO, in_ready<=0.
  - ONE, !in_xfer & out_xfer: go EMPTY.
  - ONE, no transfer: hold.
  - TWO, out_xfer: out_data<=skid, go ONE, in_ready<=1. No in_xfer is possible because in_ready=0.
  - TWO, !out_xfer: hold.
- Latency: 1 cycle from in_xfer to out_valid when the stage is empty. Sustained throughput is 1 word/cycle with out_ready held at 1.
- Ordering is strict FIFO: a skid word always leaves before any later word.
- flush=1 at an edge:
  - Next state EMPTY: out_valid=0, in_ready=1, out_data and skid = RST_VALUE.
  - Any in_xfer or out_xfer on that edge is discarded.
  - Flush has priority over all transitions.
- Reset asserted mid-transfer: the word is lost and there is no partial state. The first post-reset edge behaves as EMPTY.
- in_data is ignored whenever in_ready=0, even if in_valid=1.
- No data width conversion; all paths are N bits straight through.

Decomposition:
- Shared package pipe_pkg:
  - State encoding constants ST_EMPTY=2'b00, ST_ONE=2'b01, ST_TWO=2'b11.
  - Handshake helper localparams.
- One sub-module, pipe_data_hold: N-bit register with asynchronous active-low reset to RST_VALUE, synchronous clear and load enable.
  - Instantiated twice, once for out_data and once for the skid word.
- The state/control logic stays in pipe_skid_reg.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release. Required: out_valid=0, in_ready=1, out_data=0x00000000, and these stay stable for 5 idle cycles.
- Streaming: send 0x11,0x22,0x33,0x44 back-to-back with out_ready=1. Required: out_data 0x11..0x44 on consecutive cycles starting 1 cycle after the first accept, and in_ready stays 1.
- Stall/skid:
  - Stimulus: send 0xA1 then 0xA2 with out_ready=0. Required: in_ready drops to 0 after 0xA2; out_data holds 0xA1.
  - Stimulus: raise out_ready. Required: outputs are 0xA1 then 0xA2, and in_ready returns to 1 after the first drain.
- Ignored input while full: in state TWO, drive in_valid=1, in_data=0xDEAD. Required: the word is never output, and after draining only 0xA1 and 0xA2 appear.
- Flush: in TWO, assert flush with out_ready=1 for 1 cycle. Required: next cycle out_valid=0, in_ready=1, out_data=RST_VALUE, and no held word ever emerges.
- Async reset mid-stream: drop reset between edges while in ONE with 0x55. Required: out_valid=0 and out_data=RST_VALUE before the next clk edge; the next accepted word 0x66 appears alone.
